store_buffer: RTL and testbench
===============================

# store_buffer

Posted-write buffer between the CPU's MEM stage and the data memory (`dm`). It accepts stores from MEM without stalling, holds up to `DEPTH` entries in order, and drains one entry per cycle into `dm` whenever the load path is not using the port. It also checks loads against pending stores, so that `dm` reads never return stale data. This covers the end-of-test flag write to `'hfffc`.

## Interface
- `DEPTH`, 4: number of entries; power of two, ≥2.
- `ADDR_W`, 16: byte address width of `dm`.
- `STARVE_LIM`, 8: consecutive blocked-drain cycles before `drain_prio` asserts.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `st_valid` in 1: MEM stage presents a store.
- `st_ready` out 1: entry available.
- `st_addr` in `ADDR_W`: store byte address; bits [1:0] are ignored.
- `st_wdata` in 32: store data, already lane-aligned.
- `st_be` in 4: byte enables.
- `ld_valid` in 1: MEM stage presents a load.
- `ld_addr` in `ADDR_W`: load address.
- `ld_be` in 4: bytes the load needs.
- `ld_stall` out 1: the load must be held in MEM this cycle.
- `ld_hit` out 1: the load is served from the buffer.
- `ld_data` out 32: forwarded word, valid when `ld_hit`.
- `dm_busy` in 1: the load path owns the `dm` port this cycle.
- `dm_we` out 4: byte write enables to `dm`.
- `dm_addr` out `ADDR_W`: word-aligned write address.
- `dm_wdata` out 32: write data.
- `drain_prio` out 1: the head entry is starved, so the CPU must withhold `dm_busy`.
- `count` out clog2(`DEPTH`+1): number of valid entries.
- `empty` out 1: `count` == 0.

## Operation
- **Storage.** Circular FIFO with head and tail pointers. Each pointer carries an extra wrap bit. Full is `ptr` equal with the wrap bit differing; empty is all bits equal.
- **Enqueue.** Occurs on `st_valid && st_ready`. `st_ready = !full` and has no combinational dependence on the drain.
- **Drain.** Occurs when `!empty && !dm_busy`.
  - `dm_we`, `dm_addr` and `dm_wdata` are driven from the head entry.
  - The head pops at the clock edge.
  - Otherwise `dm_we` = 0 and the other two outputs hold their last value.
- **Simultaneous enqueue and drain.** `count` is unchanged. A full buffer does not accept a store in the same cycle it drains.
- **Load check.** An entry overlaps a load when both hold: word address match (`[ADDR_W-1:2]`) and `(entry.be & ld_be) != 0`. Of all overlapping entries, the youngest wins.
- **Mutual exclusion.** `st_valid` and `ld_valid` are never high together, because there is one MEM stage. The bench asserts this.
- **Starvation counter.**
  - Increments each cycle in which `!empty && dm_busy`.
  - Resets to 0 on a drain or when the buffer is empty.
  - Saturates at `STARVE_LIM`.
  - `drain_prio = (counter == STARVE_LIM)`.
  - While `drain_prio` is high, `ld_stall` = 1 for any `ld_valid`.
- **Reset (async, `rst` low).**
  - Pointers, `count` and counter are cleared; `empty` = 1, `st_ready` = 1.
  - `dm_we` = 0, `ld_stall` = 0, `ld_hit` = 0, `ld_data` = 0, `drain_prio` = 0.
  - Pending stores are discarded, including on reset mid-drain.

## Timing
- A store accepted at edge N is visible to the load check and to the drain from cycle N+1. It is written to `dm` at the earliest on the edge ending cycle N+1.
- `ld_stall`, `ld_hit`, `ld_data`, `dm_we`, `dm_addr`, `dm_wdata` and `drain_prio` are combinational from registered state and same-cycle inputs.
- Throughput is one enqueue and one drain per cycle.
- Worst-case drain wait is `STARVE_LIM`+1 cycles after the entry reaches the head.

## Configuration
- **With `STORE_FWD_EN` defined:**
  - The youngest overlapping entry with `(entry.be & ld_be) == ld_be` gives `ld_hit` = 1 and `ld_data` = entry data.
  - Partial coverage gives `ld_stall` = 1.
  - No overlap gives neither signal.
- **Without `STORE_FWD_EN`:**
  - Any overlap gives `ld_stall` = 1 until the matching entries drain.
  - `ld_hit` and `ld_data` are tied to 0.

## Structure
- Package `store_buffer_pkg` holds:
  - `sb_entry_t`: struct of word address, data and `be`.
  - Default `DEPTH` and `STARVE_LIM`.
  - The pointer-width function.
- Sub-module `store_buffer_match`: combinational overlap detection plus youngest-first priority select over the entry array. Inputs are the entry array, a valid mask derived from head/tail, and the load request; outputs are overlap, full-cover and the selected data.

## Test plan
- **Basic drain.** Store `'h9000`/`'h12345678`/`be=F` with `dm_busy`=0 → `dm_we`=F, `dm_addr`=`'h9000` one cycle later; `count` returns to 0.
- **Fill.** Four stores with `dm_busy`=1 → `st_ready`=0 and `count`=4. Release `dm_busy` → four writes in FIFO order on consecutive cycles.
- **Forward.**
  - Store `'h9004`=`'hAABBCCDD` `be=F`, then load `'h9004` `be=1` → with `STORE_FWD_EN`, `ld_hit`=1, `ld_data`=`'hAABBCCDD`; without it, `ld_stall`=1 until drained.
  - Store `be=1`, then load `be=F` at the same word → `ld_stall`=1 in both builds.
- **Youngest wins.** Stores `'h9008`=1 then `'h9008`=2 → load returns 2.
- **Starvation.** Hold `dm_busy`=1 with one entry pending → `drain_prio`=1 on the 8th blocked cycle and `ld_stall`=1. Drop `dm_busy` → drain, `drain_prio`=0.
- **Reset.** Assert `rst` low with 3 entries pending → all outputs take reset values immediately and no `dm_we` pulse follows.

Source files
------------

// File: rtl/store_buffer_pkg.sv
// store_buffer_pkg: shared types and defaults for the posted-write store buffer.
// Holds the entry struct, default sizing and the pointer-width helper.
package store_buffer_pkg;

  localparam int SB_DEPTH      = 4;
  localparam int SB_STARVE_LIM = 8;
  // word-address field wide enough for any ADDR_W up to 32
  localparam int SB_WA_W       = 30;

  typedef struct packed {
    logic [SB_WA_W-1:0] waddr;
    logic [31:0]        data;
    logic [3:0]         be;
  } sb_entry_t;

  function automatic int sb_ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/store_buffer_match.sv
// store_buffer_match: load-vs-pending-store overlap check, youngest wins.
// in: ent_i/vld_i/head_i entry array+mask+head, ld_waddr_i/ld_be_i load;
// out: ovl_o any overlap, cover_o youngest covers ld_be, data_o its data.
module store_buffer_match
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH,
  parameter int PW    = sb_ptr_w(DEPTH)
) (
  input  sb_entry_t          ent_i [DEPTH],
  input  logic [DEPTH-1:0]   vld_i,
  input  logic [PW-1:0]      head_i,
  input  logic [SB_WA_W-1:0] ld_waddr_i,
  input  logic [3:0]         ld_be_i,
  output logic               ovl_o,
  output logic               cover_o,
  output logic [31:0]        data_o
);

  logic [PW-1:0] idx;
  logic [3:0]    sel_be;

  // walk oldest to youngest so the last hit is the youngest
  always_comb begin
    idx    = '0;
    ovl_o  = 1'b0;
    sel_be = 4'h0;
    data_o = 32'h0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head_i + PW'(k);
      if (vld_i[idx] &&
          ent_i[idx].waddr == ld_waddr_i &&
          |(ent_i[idx].be & ld_be_i)) begin
        ovl_o  = 1'b1;
        sel_be = ent_i[idx].be;
        data_o = ent_i[idx].data;
      end
    end
    cover_o = ovl_o && ((sel_be & ld_be_i) == ld_be_i);
  end

endmodule

// File: rtl/store_buffer.sv
// store_buffer: posted-write FIFO between MEM and dm with load hazard check.
// Ports: clk, rst (async low); st_* store in; ld_* load check; dm_* drain;
// drain_prio starvation flag; count/empty occupancy. Option: STORE_FWD_EN.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH      = SB_DEPTH,
  parameter int ADDR_W     = 16,
  parameter int STARVE_LIM = SB_STARVE_LIM,
  localparam int PW = sb_ptr_w(DEPTH),
  localparam int CW = $clog2(DEPTH + 1),
  localparam int SW = $clog2(STARVE_LIM + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              st_valid,
  output logic              st_ready,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [31:0]       st_wdata,
  input  logic [3:0]        st_be,
  input  logic              ld_valid,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [3:0]        ld_be,
  output logic              ld_stall,
  output logic              ld_hit,
  output logic [31:0]       ld_data,
  input  logic              dm_busy,
  output logic [3:0]        dm_we,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [31:0]       dm_wdata,
  output logic              drain_prio,
  output logic [CW-1:0]     count,
  output logic              empty
);

  logic [PW:0]       head_q, head_d;
  logic [PW:0]       tail_q, tail_d;
  logic [SW-1:0]     stv_q, stv_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wd_q, wd_d;
  sb_entry_t         mem_q [DEPTH];

  logic              full, push, pop;
  logic [PW:0]       used;
  logic [DEPTH-1:0]  vld;
  sb_entry_t         hd;
  logic              ovl, cov;
  logic [31:0]       mdata;
  logic              unused_bits;

  assign used  = tail_q - head_q;
  assign empty = (head_q == tail_q);
  assign full  = (head_q[PW-1:0] == tail_q[PW-1:0]) &&
                 (head_q[PW] != tail_q[PW]);
  assign count = CW'(used);

  // ready depends on state only; a full buffer never takes a store
  assign st_ready = !full;
  assign push     = st_valid && !full;
  assign pop      = !empty && !dm_busy;

  assign hd       = mem_q[head_q[PW-1:0]];
  assign dm_we    = pop ? hd.be : 4'h0;
  assign dm_addr  = pop ? {hd.waddr[ADDR_W-3:0], 2'b00} : addr_q;
  assign dm_wdata = pop ? hd.data : wd_q;

  assign head_d = pop  ? head_q + 1'b1 : head_q;
  assign tail_d = push ? tail_q + 1'b1 : tail_q;
  assign addr_d = dm_addr;
  assign wd_d   = dm_wdata;

  assign drain_prio = (stv_q == SW'(STARVE_LIM));

  // any non-empty, non-draining cycle is a blocked one
  always_comb begin
    stv_d = stv_q;
    if (empty || pop)
      stv_d = '0;
    else if (!drain_prio)
      stv_d = stv_q + 1'b1;
  end

  // slot i is live when its age behind head is below occupancy
  always_comb begin
    vld = '0;
    for (int i = 0; i < DEPTH; i++)
      vld[i] = ({1'b0, PW'(i) - head_q[PW-1:0]} < used);
  end

  store_buffer_match #(
    .DEPTH(DEPTH),
    .PW   (PW)
  ) u_match (
    .ent_i     (mem_q),
    .vld_i     (vld),
    .head_i    (head_q[PW-1:0]),
    .ld_waddr_i(SB_WA_W'(ld_addr[ADDR_W-1:2])),
    .ld_be_i   (ld_be),
    .ovl_o     (ovl),
    .cover_o   (cov),
    .data_o    (mdata)
  );

`ifdef STORE_FWD_EN
  assign ld_stall = ld_valid && (drain_prio || (ovl && !cov));
  assign ld_hit   = ld_valid && !drain_prio && ovl && cov;
  assign ld_data  = ld_hit ? mdata : 32'h0;
  assign unused_bits = ^{st_addr[1:0], ld_addr[1:0], hd};
`else
  assign ld_stall = ld_valid && (drain_prio || ovl);
  assign ld_hit   = 1'b0;
  assign ld_data  = 32'h0;
  assign unused_bits = ^{st_addr[1:0], ld_addr[1:0], hd, cov, mdata};
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q <= '0;
      tail_q <= '0;
      stv_q  <= '0;
      addr_q <= '0;
      wd_q   <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      stv_q  <= stv_d;
      addr_q <= addr_d;
      wd_q   <= wd_d;
    end
  end

  // payload needs no reset; pointers define what is live
  always_ff @(posedge clk) begin
    if (push)
      mem_q[tail_q[PW-1:0]] <= '{
        waddr: SB_WA_W'(st_addr[ADDR_W-1:2]),
        data:  st_wdata,
        be:    st_be
      };
  end

endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: scoreboard bench for store_buffer.
// Expected dm writes are queued on store acceptance and popped per dm_we.
module tb_store_buffer;

`ifdef STORE_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  typedef struct {
    logic [15:0] a;
    logic [31:0] d;
    logic [3:0]  be;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        st_valid, st_ready;
  logic [15:0] st_addr;
  logic [31:0] st_wdata;
  logic [3:0]  st_be;
  logic        ld_valid;
  logic [15:0] ld_addr;
  logic [3:0]  ld_be;
  logic        ld_stall, ld_hit;
  logic [31:0] ld_data;
  logic        dm_busy;
  logic [3:0]  dm_we;
  logic [15:0] dm_addr;
  logic [31:0] dm_wdata;
  logic        drain_prio;
  logic [2:0]  count;
  logic        empty;

  int   n_chk = 0;
  int   n_err = 0;
  int   n_wr  = 0;
  int   w0;
  exp_t q[$];
  exp_t me;

  always #5 clk = ~clk;

  store_buffer dut (
    .clk(clk), .rst(rst),
    .st_valid(st_valid), .st_ready(st_ready),
    .st_addr(st_addr), .st_wdata(st_wdata), .st_be(st_be),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_be(ld_be),
    .ld_stall(ld_stall), .ld_hit(ld_hit), .ld_data(ld_data),
    .dm_busy(dm_busy), .dm_we(dm_we),
    .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .drain_prio(drain_prio), .count(count), .empty(empty)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk)
    if (rst)
      assert (!(st_valid && ld_valid))
      else $error("FAIL mutex st_valid and ld_valid both high");

  // scoreboard side: every dm write must match the oldest queued store
  always @(negedge clk) begin
    if (rst && dm_we != 4'h0) begin
      n_wr++;
      if (q.size() == 0) begin
        chk("unexp_wr", {60'h0, dm_we}, 64'h0);
      end else begin
        me = q.pop_front();
        chk("wr_be", {60'h0, dm_we}, {60'h0, me.be});
        chk("wr_addr", {48'h0, dm_addr}, {48'h0, me.a[15:2], 2'b00});
        chk("wr_data", {32'h0, dm_wdata}, {32'h0, me.d});
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_store(input logic [15:0] a, input logic [31:0] d,
                          input logic [3:0] be);
    int   t;
    exp_t e;
    t = 0;
    st_valid = 1'b1;
    st_addr  = a;
    st_wdata = d;
    st_be    = be;
    #1;
    while (!st_ready && t < 50) begin
      tick;
      t++;
    end
    if (!st_ready) begin
      chk("st_timeout", 64'd0, 64'd1);
    end else begin
      e.a  = a;
      e.d  = d;
      e.be = be;
      q.push_back(e);
    end
    tick;
    st_valid = 1'b0;
  endtask

  task automatic do_load(input string tag, input logic [15:0] a,
                         input logic [3:0] be, input logic xs,
                         input logic xh, input logic [31:0] xd);
    ld_valid = 1'b1;
    ld_addr  = a;
    ld_be    = be;
    #1;
    chk({tag, "_stall"}, {63'h0, ld_stall}, {63'h0, xs});
    chk({tag, "_hit"}, {63'h0, ld_hit}, {63'h0, xh});
    chk({tag, "_data"}, {32'h0, ld_data}, {32'h0, xd});
    ld_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    st_valid = 1'b0; st_addr = '0; st_wdata = '0; st_be = '0;
    ld_valid = 1'b0; ld_addr = '0; ld_be = '0;
    dm_busy = 1'b0;
    #3;
    chk("rst_count", {61'h0, count}, 64'd0);
    chk("rst_empty", {63'h0, empty}, 64'd1);
    chk("rst_ready", {63'h0, st_ready}, 64'd1);
    chk("rst_we", {60'h0, dm_we}, 64'd0);
    chk("rst_prio", {63'h0, drain_prio}, 64'd0);
    chk("rst_stall", {63'h0, ld_stall}, 64'd0);
    chk("rst_hit", {63'h0, ld_hit}, 64'd0);
    chk("rst_ldata", {32'h0, ld_data}, 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    tick;

    // basic drain
    dm_busy = 1'b0;
    do_store(16'h9000, 32'h12345678, 4'hF);
    chk("basic_cnt1", {61'h0, count}, 64'd1);
    tick;
    chk("basic_cnt0", {61'h0, count}, 64'd0);
    chk("basic_empty", {63'h0, empty}, 64'd1);

    // fill, then drain in order
    dm_busy = 1'b1;
    for (int i = 0; i < 4; i++)
      do_store(16'h9010 + 16'(4 * i), 32'hC0DE0000 + i, 4'hF - 4'(i));
    chk("fill_ready", {63'h0, st_ready}, 64'd0);
    chk("fill_cnt", {61'h0, count}, 64'd4);
    w0 = n_wr;
    st_valid = 1'b1;
    st_addr  = 16'h9FF0;
    dm_busy  = 1'b0;
    #1;
    chk("full_drain_ready", {63'h0, st_ready}, 64'd0);
    tick;
    st_valid = 1'b0;
    chk("full_no_push", {61'h0, count}, 64'd3);
    repeat (3) tick;
    chk("fill_cnt0", {61'h0, count}, 64'd0);
    chk("fill_nwr", 64'(n_wr - w0), 64'd4);

    // load checks against pending stores
    dm_busy = 1'b1;
    do_store(16'h9004, 32'hAABBCCDD, 4'hF);
    do_load("fwd_full", 16'h9004, 4'h1, !FWD, FWD,
            FWD ? 32'hAABBCCDD : 32'h0);
    do_store(16'h900C, 32'h00000011, 4'h1);
    do_load("fwd_part", 16'h900C, 4'hF, 1'b1, 1'b0, 32'h0);
    do_store(16'h9008, 32'h1, 4'hF);
    do_store(16'h9008, 32'h2, 4'hF);
    do_load("youngest", 16'h9008, 4'hF, !FWD, FWD,
            FWD ? 32'h2 : 32'h0);
    do_load("no_ovl", 16'h9010, 4'hF, 1'b0, 1'b0, 32'h0);
    dm_busy = 1'b0;
    repeat (4) tick;
    chk("fwd_cnt0", {61'h0, count}, 64'd0);
    do_load("drained", 16'h9004, 4'h1, 1'b0, 1'b0, 32'h0);

    // starvation
    dm_busy = 1'b1;
    do_store(16'h9100, 32'h5A5A5A5A, 4'hF);
    repeat (7) tick;
    chk("starve_pre", {63'h0, drain_prio}, 64'd0);
    tick;
    chk("starve_prio", {63'h0, drain_prio}, 64'd1);
    do_load("starve_ld", 16'h9200, 4'hF, 1'b1, 1'b0, 32'h0);
    tick;
    chk("starve_sat", {63'h0, drain_prio}, 64'd1);
    dm_busy = 1'b0;
    tick;
    chk("starve_clr", {63'h0, drain_prio}, 64'd0);
    chk("starve_cnt0", {61'h0, count}, 64'd0);

    // reset with pending entries
    dm_busy = 1'b1;
    for (int i = 0; i < 3; i++)
      do_store(16'h9300 + 16'(4 * i), 32'hDEAD0000 + i, 4'hF);
    chk("pre_rst_cnt", {61'h0, count}, 64'd3);
    rst = 1'b0;
    dm_busy = 1'b0;
    #1;
    chk("arst_count", {61'h0, count}, 64'd0);
    chk("arst_empty", {63'h0, empty}, 64'd1);
    chk("arst_we", {60'h0, dm_we}, 64'd0);
    chk("arst_ready", {63'h0, st_ready}, 64'd1);
    q.delete();
    w0 = n_wr;
    @(negedge clk);
    rst = 1'b1;
    repeat (5) tick;
    chk("arst_no_wr", 64'(n_wr - w0), 64'd0);
    chk("sb_left", 64'(q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
